// File: rtl/aes_arb.sv
// Two-requester round-robin front end for a shared, non-stalling pipelined aes_128 core.
// Results return in acceptance order through a response FIFO; a credit count caps outstanding work at DEPTH.
module aes_arb #(
    parameter int LAT   = 21,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic [127:0] core_in,
    input  logic [127:0] core_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_data,
    output logic         busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic         id;
        logic [127:0] data;
    } rsp_t;

    logic           last_grant, gnt, credit, acc0, acc1, accept, pop, wr;
    logic [CW-1:0]  count, fifo_cnt;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [LAT-1:0] vld_pipe, id_pipe;
    rsp_t           mem [DEPTH];
    rsp_t           head, hold;

    // A lone requester always wins; on contention (or idle) favour the one not granted last.
    always_comb begin
        gnt = ~last_grant;
        if (req0_valid != req1_valid) gnt = req1_valid;
    end

    // Credit comes from the registered count, so a pop frees a slot only from the next cycle.
    assign credit     = !rst && (count < CW'(DEPTH));
    assign req0_ready = credit && !gnt;
    assign req1_ready = credit && gnt;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign accept     = acc0 || acc1;
    assign core_in    = acc0 ? req0_data : (acc1 ? req1_data : 128'h0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            count      <= '0;
        end else begin
            if (accept) last_grant <= acc1;
            if (accept && !pop)      count <= count + CW'(1);
            else if (pop && !accept) count <= count - CW'(1);
        end
    end

    // Tag pipeline mirrors the core latency; core contents themselves are never reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= accept;
            id_pipe[0]  <= acc1;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    assign wr        = vld_pipe[LAT-1];
    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign head      = mem[rd_ptr];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {id_pipe[LAT-1], core_out};
    end

    // hold keeps the last presented response so the outputs stay stable while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            hold     <= '0;
        end else begin
            if (wr) wr_ptr <= nxt(wr_ptr);
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
                hold   <= head;
            end
            if (wr && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
            else if (pop && !wr) fifo_cnt <= fifo_cnt - CW'(1);
        end
    end

    assign rsp_id   = rsp_valid ? head.id   : hold.id;
    assign rsp_data = rsp_valid ? head.data : hold.data;
    assign busy     = (count != '0);
endmodule

// File: tb/tb_aes_arb.sv
// Bench for aes_arb: core stubbed as a LAT-deep delay line; queue-based reference model checks every cycle,
// plus a grant table and hand sequences for latency, backpressure and mid-operation reset.
module tb_aes_arb;
    localparam int LAT   = 21;
    localparam int DEPTH = 4;
    localparam logic [127:0] SINGLE = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0, rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [127:0] req0_data = '0, req1_data = '0;
    logic         req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [127:0] core_in, core_out, rsp_data;
    logic [127:0] dl [LAT];
    int           n_chk = 0, n_err = 0;

    aes_arb #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .core_in(core_in), .core_out(core_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Core stub: result equals operand, LAT cycles later.
    always @(posedge clk) begin
        dl[0] <= core_in;
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
    assign core_out = dl[LAT-1];

    task automatic chk(input string name, input logic [128:0] got, input logic [128:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] pack_q(input logic q[$]);
        logic [7:0] r = '0;
        foreach (q[i]) if (i < 8) r = {r[6:0], q[i]};
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int due; logic id; logic [127:0] d; } flight_t;
    flight_t      inflight[$];
    logic [128:0] fifo_q[$];
    logic         m_last = 1'b1;
    logic [127:0] m_hold = '0;
    int           cyc = 0;
    logic         dut_acc[$], dut_rsp[$];

    always @(negedge clk) begin
        logic g, e0, e1, pop, full;
        #2;
        if (rst) begin
            inflight.delete(); fifo_q.delete();
            m_last = 1'b1; m_hold = '0; cyc = 0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", {req0_ready, req1_ready}, 0);
        end else begin
            full = (inflight.size() + fifo_q.size()) >= DEPTH;
            g  = (req0_valid != req1_valid) ? req1_valid : !m_last;
            e0 = req0_valid && !full && !g;
            e1 = req1_valid && !full && g;
            chk("acc0", req0_valid && req0_ready, e0);
            chk("acc1", req1_valid && req1_ready, e1);
            chk("ready_without_credit", full && (req0_ready || req1_ready), 0);
            chk("core_in", core_in, e0 ? req0_data : (e1 ? req1_data : 128'h0));
            chk("rsp_valid", rsp_valid, fifo_q.size() != 0);
            if (fifo_q.size() != 0) chk("rsp_head", {rsp_id, rsp_data}, fifo_q[0]);
            else                    chk("rsp_data_hold", rsp_data, m_hold);
            chk("busy", busy, (inflight.size() + fifo_q.size()) != 0);
            if (req0_valid && req0_ready) dut_acc.push_back(1'b0);
            if (req1_valid && req1_ready) dut_acc.push_back(1'b1);
            if (rsp_valid && rsp_ready)   dut_rsp.push_back(rsp_id);
            pop = (fifo_q.size() != 0) && rsp_ready;
            if (pop) begin
                m_hold = fifo_q[0][127:0];
                void'(fifo_q.pop_front());
            end
            while (inflight.size() != 0 && inflight[0].due == cyc) begin
                fifo_q.push_back({inflight[0].id, inflight[0].d});
                void'(inflight.pop_front());
            end
            if (e0 || e1) begin
                inflight.push_back('{cyc + LAT, e1, e1 ? req1_data : req0_data});
                m_last = e1;
            end
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dut_acc.delete(); dut_rsp.delete();
    endtask

    task automatic wait_rsp(input string name, input int n, input int budget);
        int k = 0;
        while (dut_rsp.size() < n && k < budget) begin
            @(negedge clk); k++;
        end
        @(negedge clk); #3;
        chk(name, dut_rsp.size(), n);
    endtask

    typedef struct {
        logic v0, v1;
        logic [127:0] d0, d1;
        logic r0, r1;
        logic [127:0] ci;
    } vec_t;
    vec_t tbl [7];

    function automatic logic [127:0] dv(input int i);
        return {4{32'hC0DE0000 + i}};
    endfunction

    initial begin
        int first, nbusy, nvalid, cnt;
        // Grant/credit table from reset (last_grant=1, count=0), rsp_ready=1.
        tbl[0] = '{1'b1, 1'b1, dv(0),  dv(1),  1'b1, 1'b0, dv(0)};
        tbl[1] = '{1'b1, 1'b1, dv(2),  dv(3),  1'b0, 1'b1, dv(3)};
        tbl[2] = '{1'b0, 1'b1, dv(4),  dv(5),  1'b0, 1'b1, dv(5)};
        tbl[3] = '{1'b1, 1'b0, dv(6),  dv(7),  1'b1, 1'b0, dv(6)};
        tbl[4] = '{1'b1, 1'b1, dv(8),  dv(9),  1'b0, 1'b0, 128'h0};
        tbl[5] = '{1'b0, 1'b0, dv(10), dv(11), 1'b0, 1'b0, 128'h0};
        tbl[6] = '{1'b0, 1'b1, dv(12), dv(13), 1'b0, 1'b0, 128'h0};

        repeat (3) @(negedge clk);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
            req0_data  = tbl[i].d0; req1_data  = tbl[i].d1; rsp_ready = 1'b1;
            #1;
            chk($sformatf("tbl%0d_r0", i), req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_r1", i), req1_ready, tbl[i].r1);
            chk($sformatf("tbl%0d_core_in", i), core_in, tbl[i].ci);
        end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp("tbl_rsp_count", 4, 3 * LAT);
        chk("tbl_acc_order", pack_q(dut_acc), 8'b0110);
        chk("tbl_rsp_order", pack_q(dut_rsp), 8'b0110);

        // Single request: latency LAT+1, busy for LAT+1 cycles, exactly one response.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = SINGLE; rsp_ready = 1'b1;
        #1;
        chk("single_ready", req0_ready, 1);
        chk("single_core_in", core_in, SINGLE);
        first = -1; nbusy = 0; nvalid = 0;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk); req0_valid = 1'b0; #1;
            if (busy) nbusy++;
            if (rsp_valid) begin
                nvalid++;
                if (first < 0) begin
                    first = k;
                    chk("single_id", rsp_id, 0);
                    chk("single_data", rsp_data, SINGLE);
                end
            end
        end
        chk("single_latency", first, LAT + 1);
        chk("single_busy_cycles", nbusy, LAT + 1);
        chk("single_rsp_count", nvalid, 1);

        // Backpressure: 6 offered with rsp_ready=0, only DEPTH accepted, then drain.
        do_reset();
        for (int k = 0; k < LAT + 8; k++) begin
            @(negedge clk);
            req0_valid = dut_acc.size() < 6; req1_valid = dut_acc.size() < 6; rsp_ready = 1'b0;
            req0_data = {$urandom, $urandom, $urandom, $urandom};
            req1_data = {$urandom, $urandom, $urandom, $urandom};
        end
        #1;
        chk("bp_accepted", dut_acc.size(), DEPTH);
        chk("bp_ready_low", req0_ready || req1_ready, 0);
        chk("bp_rsp_pending", {rsp_valid, busy}, 2'b11);
        @(negedge clk); rsp_ready = 1'b1;
        #1;
        chk("bp_credit_next_cycle", req0_ready || req1_ready, 0);
        cnt = 0;
        while (dut_rsp.size() < 6 && cnt < 4 * LAT) begin
            @(negedge clk);
            req0_valid = dut_acc.size() < 6; req1_valid = dut_acc.size() < 6;
            req0_data = {$urandom, $urandom, $urandom, $urandom};
            req1_data = {$urandom, $urandom, $urandom, $urandom};
            cnt++;
        end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0; #3;
        chk("bp_rsp_count", dut_rsp.size(), 6);
        chk("bp_acc_order", pack_q(dut_acc), 8'b010101);
        chk("bp_rsp_order", pack_q(dut_rsp), 8'b010101);

        // Reset mid-operation: two in flight, reset 5 cycles later, nothing may emerge.
        do_reset();
        @(negedge clk); req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rmid_acc_count", dut_acc.size(), 2);
        repeat (4) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rmid_rsp_valid", rsp_valid, 0);
        chk("rmid_rsp_id", rsp_id, 0);
        chk("rmid_rsp_data", rsp_data, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_ready", {req0_ready, req1_ready}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk); #1;
            if (rsp_valid) nvalid++;
        end
        chk("rmid_no_stale_rsp", nvalid, 0);

        // Randomized traffic against the model, then drain.
        do_reset();
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            req0_valid = $urandom_range(1, 0) == 1;
            req1_valid = $urandom_range(1, 0) == 1;
            rsp_ready  = (k % 100 < 30) ? ($urandom_range(7, 0) == 0) : ($urandom_range(2, 0) != 0);
            req0_data = {$urandom, $urandom, $urandom, $urandom};
            req1_data = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (LAT + 2 * DEPTH + 4) @(negedge clk);
        #3;
        chk("rand_all_returned", dut_rsp.size(), dut_acc.size());
        chk("rand_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
